instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential instruction encoder and writer for the single-cycle CPU's instruction memory: the inverse of the main control decoder. It accepts field-level instruction requests over a valid/ready handshake, packs each into a 32-bit word using the team's opcode map, and writes the words to consecutive instruction-memory locations. It is used by the boot/test loader to fill instruction memory before the CPU is released from reset.

## Interface
- AW, 6, word-address width of instruction memory
- DEPTH, 64, number of words that may be written (must be ≤ 2^AW)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous clear: pointer to 0, abort pending write, leave DONE
- req_valid_i  in  1  request present
- req_ready_o  out  1  encoder can accept a request this cycle
- req_last_i  in  1  accepted request is the final word of the program
- kind_i  in  3  0=R-type, 1=ALU-immediate, 2=lw, 3=sw, 4=beq, 5=bne, 6=j, 7=jal
- rs_i, rt_i, rd_i, shamt_i  in  5 each  register / shift fields
- funct_i  in  6  R-type function field
- imm_i  in  16  immediate / branch offset, passed unmodified
- target_i  in  26  jump target field, passed unmodified
- mem_we_o  out  1  instruction-memory write strobe
- mem_addr_o  out  AW  word address of the current write
- mem_data_o  out  32  encoded instruction word
- count_o  out  AW+1  words written since reset/flush
- full_o  out  1  count_o == DEPTH
- done_o  out  1  last word written; no further requests accepted

## Operation
- Opcode map ([31:26]): R=111111, ALU-imm=110111, lw=100001, sw=100011, beq=111011, bne=100101, j=100010, jal=100111.
- R-type word: {op, rs, rt, rd, shamt, funct}. Kinds 1–5: {op, rs, rt, imm}. Kinds 6–7: {op, target}. Fields not used by a kind are ignored.
- FSM states: ACCEPT, WRITE, DONE.
  - ACCEPT: req_ready_o = !full_o && !flush_i. Handshake (valid && ready) at a rising edge registers the encoded word and the last flag and moves to WRITE.
  - WRITE: mem_we_o = 1, mem_addr_o = write pointer, mem_data_o = registered word. At the next edge, pointer and count_o increment by 1. Next state is DONE if last flag set, else ACCEPT.
  - DONE: done_o = 1, req_ready_o = 0, mem_we_o = 0. Held until flush_i or reset.
- Full: when count_o reaches DEPTH, req_ready_o stays low in ACCEPT and no write occurs. The pointer never wraps. Only flush_i or reset recovers.
- flush_i has priority in every state. At the edge it is sampled high: state becomes ACCEPT, pointer and count_o become 0, done_o is cleared. A WRITE in progress is aborted: count_o does not increment, and mem_we_o is low from the following cycle onward.
- req_valid_i with req_ready_o low: no effect. The requester must hold its request.

## Timing
- Reset (rst_i low, asynchronous): state=ACCEPT, pointer=0, count_o=0, encoded word=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, full_o=0, done_o=0. req_ready_o=1 once flush_i is low.
- Latency: accepted at edge N → mem_we_o high for exactly cycle N..N+1 with the word at pointer value p → count_o = p+1 after edge N+1.
- Throughput: one word per 2 cycles. req_ready_o is low during WRITE.
- mem_addr_o and mem_data_o are stable for the whole cycle in which mem_we_o is high.
- Reset asserted mid-WRITE: mem_we_o drops asynchronously, and the word is not counted.

## Test plan
- Reset, then R-type rs=1 rt=2 rd=3 shamt=0 funct=0x20 → mem_we_o for 1 cycle, addr 0, data 0xFC221820; count_o=1.
- lw rs=4 rt=5 imm=0x0010, then bne rs=1 rt=0 imm=0xFFFE, back-to-back valid → 0x84850010 at addr 0 and 0x9420FFFE at addr 1; req_ready_o low during each WRITE cycle.
- jal target=0x0000040 with req_last_i=1 → 0x9C000040 written, then done_o=1 and req_ready_o=0; further valid requests produce no write.
- DEPTH=4, hold valid continuously for 6 requests → exactly 4 writes at addr 0–3; full_o=1, count_o=4, req_ready_o=0.
- flush_i asserted in a WRITE cycle at addr 2 → count_o=0 next cycle, mem_we_o low, next request written at addr 0.
- rst_i pulsed low asynchronously mid-WRITE → all outputs immediately at reset values; after release, the first request is written at addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - field-level instruction encoder and sequential instruction-memory writer
//
// Purpose:
//   Takes field-level instruction requests over a valid/ready handshake.
//   Each accepted request is packed into a 32-bit word using the team opcode map.
//   The words are written to consecutive instruction-memory addresses.
//   The boot/test loader uses this block to fill instruction memory before the CPU leaves reset.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-low reset
//   flush_i      synchronous clear: pointer/count to 0, abort pending write, leave DONE
//   req_valid_i  request present
//   req_ready_o  request can be accepted this cycle
//   req_last_i   accepted request is the last word of the program
//   kind_i       0=R 1=ALU-imm 2=lw 3=sw 4=beq 5=bne 6=j 7=jal
//   rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i
//                instruction fields
//   mem_we_o     write strobe
//   mem_addr_o   write address
//   mem_data_o   write data
//   count_o      words written since reset/flush
//   full_o       count_o == DEPTH
//   done_o       last word written; no further requests accepted
module instr_encoder #(
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_last_i,
  input  logic [2:0]    kind_i,
  input  logic [4:0]    rs_i,
  input  logic [4:0]    rt_i,
  input  logic [4:0]    rd_i,
  input  logic [4:0]    shamt_i,
  input  logic [5:0]    funct_i,
  input  logic [15:0]   imm_i,
  input  logic [25:0]   target_i,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_data_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          done_o
);

  typedef enum logic [1:0] {ACCEPT, WRITE, DONE} stateT;

  localparam logic [AW:0] depthW = (AW+1)'(DEPTH);

  stateT       state;
  logic [AW:0] count;
  logic [31:0] word;
  logic        lastFlag;
  logic        memWe;
  logic        doneReg;
  logic [5:0]  opcode;
  logic [31:0] encWord;
  logic        isFull;

  // The write pointer equals the count.
  // The pointer and the count both advance together on each completed write.
  // Both also clear together.
  // The pointer never wraps because writes stop at DEPTH.
  assign isFull      = (count == depthW);
  assign req_ready_o = (state == ACCEPT) && !isFull && !flush_i;
  assign mem_we_o    = memWe;
  assign mem_addr_o  = count[AW-1:0];
  assign mem_data_o  = word;
  assign count_o     = count;
  assign full_o      = isFull;
  assign done_o      = doneReg;

  always_comb begin
    opcode  = 6'b111111;
    encWord = 32'd0;
    case (kind_i)
      3'd0: opcode = 6'b111111;
      3'd1: opcode = 6'b110111;
      3'd2: opcode = 6'b100001;
      3'd3: opcode = 6'b100011;
      3'd4: opcode = 6'b111011;
      3'd5: opcode = 6'b100101;
      3'd6: opcode = 6'b100010;
      3'd7: opcode = 6'b100111;
      default: opcode = 6'b111111;
    endcase
    if (kind_i == 3'd0) begin
      encWord = {opcode, rs_i, rt_i, rd_i, shamt_i, funct_i};
    end else if (kind_i <= 3'd5) begin
      encWord = {opcode, rs_i, rt_i, imm_i};
    end else begin
      encWord = {opcode, target_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ACCEPT;
      count    <= '0;
      word     <= '0;
      lastFlag <= 1'b0;
      memWe    <= 1'b0;
      doneReg  <= 1'b0;
    end else if (flush_i) begin
      // A write in flight is dropped without being counted.
      state    <= ACCEPT;
      count    <= '0;
      lastFlag <= 1'b0;
      memWe    <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (req_valid_i && !isFull) begin
            word     <= encWord;
            lastFlag <= req_last_i;
            memWe    <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          memWe <= 1'b0;
          count <= count + 1'b1;
          if (lastFlag) begin
            state   <= DONE;
            doneReg <= 1'b1;
          end else begin
            state <= ACCEPT;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= ACCEPT;
          memWe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking randomized bench for instr_encoder
module tb_instr_encoder;

  localparam int AW    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          flush;
  logic          reqValid;
  logic          reqReady;
  logic          reqLast;
  logic [2:0]    kind;
  logic [4:0]    rs, rt, rd, shamt;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [31:0]   memData;
  logic [AW:0]   count;
  logic          full;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int unsigned opTab [8];
  int          expCount;
  bit          expDone;

  instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rstN), .flush_i(flush),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_last_i(reqLast),
    .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
    .funct_i(funct), .imm_i(imm), .target_i(target),
    .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_data_o(memData),
    .count_o(count), .full_o(full), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned refWord();
    int unsigned op;
    op = opTab[kind];
    if (kind == 0)
      return op * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + shamt * 64 + funct;
    else if (kind <= 5)
      return op * 67108864 + rs * 2097152 + rt * 65536 + imm;
    else
      return op * 67108864 + target;
  endfunction

  task automatic setReq(input int k, input int a, input int b, input int c, input int s,
                        input int f, input int i, input int t, input bit last);
    kind = 3'(k); rs = 5'(a); rt = 5'(b); rd = 5'(c); shamt = 5'(s);
    funct = 6'(f); imm = 16'(i); target = 26'(t); reqLast = last;
  endtask

  task automatic randReq(input bit last);
    setReq($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, last);
  endtask

  task automatic checkIdle(input string tag);
    checkEq({tag, "_we"}, memWe, 0);
    checkEq({tag, "_count"}, count, expCount);
    checkEq({tag, "_done"}, done, expDone);
    checkEq({tag, "_full"}, full, expCount == DEPTH);
  endtask

  // Called at a negedge with the fields already set.
  // Returns at a negedge with valid low.
  task automatic doReq();
    bit          expReady;
    int unsigned expWord;
    reqValid = 1'b1;
    #1;
    expReady = !expDone && (expCount < DEPTH);
    checkEq("ready", reqReady, expReady);
    if (expReady) begin
      expWord = refWord();
      @(posedge clk); @(negedge clk);
      checkEq("wr_we", memWe, 1);
      checkEq("wr_addr", memAddr, expCount);
      checkEq("wr_data", memData, expWord);
      checkEq("wr_ready", reqReady, 0);
      @(posedge clk); @(negedge clk);
      expCount++;
      expDone = reqLast;
      checkIdle("post");
    end else begin
      repeat (3) begin
        @(posedge clk); @(negedge clk);
        checkEq("rej_we", memWe, 0);
        checkEq("rej_ready", reqReady, 0);
        checkEq("rej_count", count, expCount);
      end
    end
    reqValid = 1'b0;
  endtask

  task automatic doFlush();
    flush = 1'b1;
    reqValid = 1'b1;
    #1;
    checkEq("flush_ready", reqReady, 0);
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    reqValid = 1'b0;
    expCount = 0;
    expDone = 0;
    checkIdle("flush");
  endtask

  // Accepts a request, then interrupts its WRITE cycle with a flush (mode 0) or a reset (mode 1).
  task automatic abortWrite(input bit useReset);
    reqValid = 1'b1;
    @(posedge clk); @(negedge clk);
    checkEq("ab_we", memWe, 1);
    checkEq("ab_addr", memAddr, expCount);
    if (!useReset) begin
      flush = 1'b1;
      @(posedge clk); @(negedge clk);
      flush = 1'b0;
    end else begin
      #2 rstN = 1'b0;
      #1;
      checkEq("rst_addr", memAddr, 0);
      checkEq("rst_data", memData, 0);
      checkEq("rst_ready", reqReady, 1);
      @(posedge clk); @(negedge clk);
      rstN = 1'b1;
    end
    reqValid = 1'b0;
    expCount = 0;
    expDone = 0;
    checkIdle("abort");
  endtask

  initial begin
    opTab[0] = 32'h3F; opTab[1] = 32'h37; opTab[2] = 32'h21; opTab[3] = 32'h23;
    opTab[4] = 32'h3B; opTab[5] = 32'h25; opTab[6] = 32'h22; opTab[7] = 32'h27;
    rstN = 1'b0; flush = 1'b0; reqValid = 1'b0;
    setReq(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expCount = 0; expDone = 0;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    checkEq("reset_addr", memAddr, 0);
    checkEq("reset_data", memData, 0);
    checkEq("reset_ready", reqReady, 1);
    rstN = 1'b1;
    @(negedge clk);

    // R-type
    setReq(0, 1, 2, 3, 0, 'h20, 0, 0, 0); doReq();
    doFlush();

    // lw then bne with continuous valid
    setReq(2, 4, 5, 0, 0, 0, 'h0010, 0, 0); doReq();
    setReq(5, 1, 0, 0, 0, 0, 'hFFFE, 0, 0); doReq();

    // jal marked last; the next request is refused
    setReq(7, 0, 0, 0, 0, 0, 0, 'h40, 1); doReq();
    checkEq("done_ready", reqReady, 0);
    randReq(0); doReq();
    doFlush();

    // Six requests against a depth of four
    for (int n = 0; n < 6; n++) begin
      randReq(0);
      doReq();
    end
    checkEq("full_count", count, DEPTH);
    doFlush();

    // Flush during the write to address 2
    randReq(0); doReq();
    randReq(0); doReq();
    randReq(0); abortWrite(0);
    randReq(0); doReq();

    // Asynchronous reset during a write
    randReq(0); abortWrite(1);
    randReq(0); doReq();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0 || ((expDone || expCount == DEPTH) && r < 8)) begin
        doFlush();
      end else if (r == 1 && !expDone && expCount < DEPTH) begin
        randReq(0);
        abortWrite($urandom_range(0, 1) == 1);
      end else begin
        randReq($urandom_range(0, 7) == 0);
        doReq();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
